edge_setup_seq: RTL and testbench

Per-line edge-function setup controller for the scanline rasterizer. Accepts one screen-space triangle from the vertex stage via a valid/ready handshake, holds it pending until the frame boundary, and during each horizontal blank sequentially computes the three edge-function start values for the next scanline on one shared multiply/subtract datapath. It drives the rasterizer's per-frame `y_screen_v*` inputs and per-line `e*_init_t1` inputs, which the rasterizer samples at x==799.

---
 rtl/raster_pkg.sv | 19 +
 rtl/edge_mac.sv | 28 ++
 rtl/edge_setup_seq.sv | 123 ++++++++++++
 tb/tb_edge_setup_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// raster_pkg: shared widths, timing constants, setup FSM states and edge saturation
package raster_pkg;
    localparam int CW = 10;
    localparam int EW = 20;
    localparam int IW = 24;
    localparam int H_TRIG = 640;
    localparam int H_LAST = 799;
    localparam int V_ACTIVE = 480;
    localparam int V_LAST = 524;
    localparam logic signed [IW-1:0] SAT_HI = 24'sd524287;
    localparam logic signed [IW-1:0] SAT_LO = -24'sd524288;
    // Encoding order matters: FRAME..COMMIT advance by +1.
    typedef enum logic [3:0] {
        S_IDLE, S_FRAME, S_MUL0, S_ACC0, S_MUL1, S_ACC1, S_MUL2, S_ACC2, S_COMMIT
    } state_t;
    function automatic logic signed [EW-1:0] sat_edge(input logic signed [IW-1:0] v);
        return (v > SAT_HI) ? 20'h7FFFF : (v < SAT_LO) ? 20'h80000 : v[EW-1:0];
    endfunction
endpackage

// File: rtl/edge_mac.sv
// edge_mac: registered 11x11 signed multiply pair with combinational difference
//   clk, reset (sync, active-low), mul_en: capture both products
//   a0*b0 -> 22-bit product, a1*b1 -> 24-bit product, diff = p0 - p1 (24-bit)
module edge_mac
    import raster_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mul_en,
    input  logic signed [10:0]   a0,
    input  logic signed [10:0]   b0,
    input  logic signed [10:0]   a1,
    input  logic signed [10:0]   b1,
    output logic signed [IW-1:0] diff
);
    logic signed [21:0]   p0;
    logic signed [IW-1:0] p1;
    always_ff @(posedge clk) begin
        if (!reset) begin
            p0 <= '0;
            p1 <= '0;
        end else if (mul_en) begin
            p0 <= 22'(a0) * 22'(b0);
            p1 <= IW'(a1) * IW'(b1);
        end
    end
    assign diff = IW'(p0) - p1;
endmodule

// File: rtl/edge_setup_seq.sv
// edge_setup_seq: per-line edge-function setup for the scanline rasterizer
//   clk, reset (sync, active-low); x, y: VGA counters
//   vtx_valid/vtx_ready + x_v*/y_v*: triangle handshake into a one-deep pending slot
//   y_screen_v*, e*_init_t1: committed triangle y values and next-line edge starts
//   tri_swap: pulse when a pending triangle goes active; busy: FSM not idle
//   Define EDGE_SETUP_SAT_EN to saturate edge values instead of wrapping.
module edge_setup_seq
    import raster_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CW-1:0]        x,
    input  logic [CW-1:0]        y,
    input  logic                 vtx_valid,
    output logic                 vtx_ready,
    input  logic signed [CW-1:0] x_v0,
    input  logic signed [CW-1:0] y_v0,
    input  logic signed [CW-1:0] x_v1,
    input  logic signed [CW-1:0] y_v1,
    input  logic signed [CW-1:0] x_v2,
    input  logic signed [CW-1:0] y_v2,
    output logic signed [EW-1:0] y_screen_v0,
    output logic signed [EW-1:0] y_screen_v1,
    output logic signed [EW-1:0] y_screen_v2,
    output logic signed [EW-1:0] e0_init_t1,
    output logic signed [EW-1:0] e1_init_t1,
    output logic signed [EW-1:0] e2_init_t1,
    output logic                 tri_swap,
    output logic                 busy
);
`ifdef EDGE_SETUP_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    state_t state, nxt;
    logic signed [CW-1:0] ax[3], ay[3], px[3], py[3];
    logic signed [IW-1:0] res[3];
    logic signed [EW-1:0] red[3];
    logic                 pend_full, swap_flag, trig, mul_en, acc_en;
    logic [CW-1:0]        line, next_line;
    logic [1:0]           sel, sel_b;
    logic signed [10:0]   a0, b0, a1, b1;
    logic signed [IW-1:0] diff;
    assign vtx_ready = !pend_full && reset;
    assign busy = (state != S_IDLE);
    always_comb begin
        next_line = (y == CW'(V_LAST)) ? '0 : y + 10'd1;
        trig = (state == S_IDLE) && (x == CW'(H_TRIG)) && (next_line < CW'(V_ACTIVE));
        nxt = (state == S_IDLE) ? (trig ? ((y == CW'(V_LAST)) ? S_FRAME : S_MUL0) : S_IDLE)
            : (state == S_COMMIT) ? S_IDLE : state_t'(state + 4'd1);
        mul_en = (state == S_MUL0) || (state == S_MUL1) || (state == S_MUL2);
        acc_en = (state == S_ACC0) || (state == S_ACC1) || (state == S_ACC2);
        sel = (state == S_MUL1 || state == S_ACC1) ? 2'd1
            : (state == S_MUL2 || state == S_ACC2) ? 2'd2 : 2'd0;
        // Edge k runs vertex k -> vertex (k+1) mod 3.
        sel_b = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
        a0 = -11'(ax[sel]);
        b0 = 11'(ay[sel_b]) - 11'(ay[sel]);
        a1 = $signed({1'b0, line}) - 11'(ay[sel]);
        b1 = 11'(ax[sel_b]) - 11'(ax[sel]);
        for (int i = 0; i < 3; i++)
            red[i] = SAT_EN ? sat_edge(res[i]) : res[i][EW-1:0];
    end
    edge_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .mul_en (mul_en),
        .a0     (a0),
        .b0     (b0),
        .a1     (a1),
        .b1     (b1),
        .diff   (diff)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            pend_full   <= 1'b0;
            swap_flag   <= 1'b0;
            line        <= '0;
            ax          <= '{default: '0};
            ay          <= '{default: '0};
            px          <= '{default: '0};
            py          <= '{default: '0};
            res         <= '{default: '0};
            y_screen_v0 <= '0;
            y_screen_v1 <= '0;
            y_screen_v2 <= '0;
            e0_init_t1  <= '0;
            e1_init_t1  <= '0;
            e2_init_t1  <= '0;
            tri_swap    <= 1'b0;
        end else begin
            state    <= nxt;
            tri_swap <= 1'b0;
            if (trig)
                line <= next_line;
            // The slot is full during a swap, so no transfer can collide with it.
            if (state == S_FRAME && pend_full) begin
                ax        <= px;
                ay        <= py;
                pend_full <= 1'b0;
                swap_flag <= 1'b1;
            end else if (vtx_valid && vtx_ready) begin
                px        <= '{x_v0, x_v1, x_v2};
                py        <= '{y_v0, y_v1, y_v2};
                pend_full <= 1'b1;
            end
            if (acc_en)
                res[sel] <= diff;
            if (state == S_COMMIT) begin
                e0_init_t1  <= red[0];
                e1_init_t1  <= red[1];
                e2_init_t1  <= red[2];
                y_screen_v0 <= EW'(ay[0]);
                y_screen_v1 <= EW'(ay[1]);
                y_screen_v2 <= EW'(ay[2]);
                tri_swap    <= swap_flag;
                swap_flag   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_edge_setup_seq.sv
// tb_edge_setup_seq: directed self-checking bench for edge_setup_seq
module tb_edge_setup_seq;
    logic clk = 1'b0;
    logic reset;
    logic [9:0] x, y;
    logic vtx_valid, vtx_ready;
    logic signed [9:0] x_v0, y_v0, x_v1, y_v1, x_v2, y_v2;
    logic signed [19:0] y_screen_v0, y_screen_v1, y_screen_v2;
    logic signed [19:0] e0_init_t1, e1_init_t1, e2_init_t1;
    logic tri_swap, busy;
    int checks = 0;
    int errors = 0;
`ifdef EDGE_SETUP_SAT_EN
    localparam int SAT_E0 = 524287;
`else
    localparam int SAT_E0 = -296927;
`endif
    edge_setup_seq dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .vtx_valid   (vtx_valid),
        .vtx_ready   (vtx_ready),
        .x_v0        (x_v0),
        .y_v0        (y_v0),
        .x_v1        (x_v1),
        .y_v1        (y_v1),
        .x_v2        (x_v2),
        .y_v2        (y_v2),
        .y_screen_v0 (y_screen_v0),
        .y_screen_v1 (y_screen_v1),
        .y_screen_v2 (y_screen_v2),
        .e0_init_t1  (e0_init_t1),
        .e1_init_t1  (e1_init_t1),
        .e2_init_t1  (e2_init_t1),
        .tri_swap    (tri_swap),
        .busy        (busy)
    );
    always #5 clk = ~clk;
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic signed [19:0] act, input int exp);
        checks++;
        assert (act === 20'(exp))
        else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask
    task automatic load(input int a, input int b, input int c, input int d, input int e, input int f);
        x_v0 = 10'(a); y_v0 = 10'(b);
        x_v1 = 10'(c); y_v1 = 10'(d);
        x_v2 = 10'(e); y_v2 = 10'(f);
    endtask
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        reset = 1'b0; x = '0; y = '0; vtx_valid = 1'b0;
        load(0, 0, 0, 0, 0, 0);
        step(2);
        chk("rst_e0", e0_init_t1, 0);
        chk("rst_ready", 20'(vtx_ready), 0);
        chk("rst_busy", 20'(busy), 0);
        reset = 1'b1;
        step(1);
        chk("idle_ready", 20'(vtx_ready), 1);
        // Triangle A loaded mid-frame.
        load(100, 100, 300, 100, 200, 300);
        y = 10'd200; vtx_valid = 1'b1;
        step(1);
        vtx_valid = 1'b0;
        chk("a_slot_full", 20'(vtx_ready), 0);
        // Frame line: outputs appear 9 edges after the trigger edge.
        y = 10'd524; x = 10'd640;
        step(1);
        x = 10'd641;
        chk("frame_busy", 20'(busy), 1);
        step(7);
        chk("frame_precommit_e0", e0_init_t1, 0);
        chk("frame_precommit_swap", 20'(tri_swap), 0);
        step(1);
        chk("a_l0_e0", e0_init_t1, 20000);
        chk("a_l0_e1", e1_init_t1, -70000);
        chk("a_l0_e2", e2_init_t1, 10000);
        chk("a_ys0", y_screen_v0, 100);
        chk("a_ys1", y_screen_v1, 100);
        chk("a_ys2", y_screen_v2, 300);
        chk("a_swap", 20'(tri_swap), 1);
        chk("a_ready_after", 20'(vtx_ready), 1);
        step(1);
        chk("a_swap_end", 20'(tri_swap), 0);
        chk("a_idle", 20'(busy), 0);
        // Non-frame line 10: visible 8 edges after trigger.
        y = 10'd9; x = 10'd640;
        step(1);
        x = 10'd641;
        step(6);
        chk("l10_pre_e1", e1_init_t1, -70000);
        step(1);
        chk("l10_e0", e0_init_t1, 18000);
        chk("l10_e1", e1_init_t1, -69000);
        chk("l10_e2", e2_init_t1, 11000);
        chk("l10_swap", 20'(tri_swap), 0);
        // Blanking lines never start setup.
        y = 10'd479; x = 10'd640;
        step(1);
        x = 10'd641;
        chk("blank479_busy", 20'(busy), 0);
        step(9);
        chk("blank479_e0", e0_init_t1, 18000);
        y = 10'd500; x = 10'd640;
        step(1);
        x = 10'd641;
        chk("blank500_busy", 20'(busy), 0);
        step(9);
        chk("blank500_e1", e1_init_t1, -69000);
        // Triangle B into the slot, then C offered while the slot is full.
        load(511, 0, -512, -512, 0, 0);
        y = 10'd100; x = 10'd0; vtx_valid = 1'b1;
        step(1);
        chk("b_slot_full", 20'(vtx_ready), 0);
        load(10, 20, 30, 40, 50, 60);
        step(3);
        chk("c_blocked", 20'(vtx_ready), 0);
        y = 10'd9; x = 10'd640;
        step(1);
        x = 10'd641;
        step(7);
        chk("a_persists_e0", e0_init_t1, 18000);
        chk("c_still_blocked", 20'(vtx_ready), 0);
        y = 10'd524; x = 10'd640;
        step(1);
        x = 10'd641;
        chk("frame_ready_lo", 20'(vtx_ready), 0);
        step(1);
        chk("frame_ready_hi", 20'(vtx_ready), 1);
        step(1);
        vtx_valid = 1'b0;
        chk("c_accepted", 20'(vtx_ready), 0);
        step(6);
        chk("b_l0_e0", e0_init_t1, 261632);
        chk("b_l0_e1", e1_init_t1, 0);
        chk("b_l0_e2", e2_init_t1, 0);
        chk("b_ys1", y_screen_v1, -512);
        chk("b_swap", 20'(tri_swap), 1);
        // Line 479 of B overflows 20 bits on edge 0.
        y = 10'd478; x = 10'd640;
        step(1);
        x = 10'd641;
        step(7);
        chk("b_l479_e0", e0_init_t1, SAT_E0);
        chk("b_l479_e1", e1_init_t1, -245248);
        chk("b_l479_e2", e2_init_t1, -244769);
        // Reset in the middle of a frame sequence that would swap in C.
        y = 10'd524; x = 10'd640;
        step(1);
        x = 10'd641;
        step(2);
        reset = 1'b0;
        step(1);
        chk("mr_e0", e0_init_t1, 0);
        chk("mr_e1", e1_init_t1, 0);
        chk("mr_ys1", y_screen_v1, 0);
        chk("mr_busy", 20'(busy), 0);
        chk("mr_ready_in_reset", 20'(vtx_ready), 0);
        reset = 1'b1; x = 10'd0;
        step(1);
        chk("mr_ready", 20'(vtx_ready), 1);
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("mr_no_swap", 20'(tri_swap), 0);
        end
        chk("mr_e2_hold", e2_init_t1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
